bp_event_counter_bank: RTL

//  Parametrised bank of els_p hardware event counters for core profiling. It generalises the fixed stall/instr counters.

---
 rtl/bp_event_counter_bank.sv | 114 +++++++++++
 1 files changed

// File: rtl/bp_event_counter_bank.sv
// bp_event_counter_bank: bank of saturating/wrapping event counters with sticky overflow,
// atomic shadow snapshots (manual or windowed) and a valid/ready read port.
module bp_event_counter_bank #(
    parameter int els_p = 8,
    parameter int width_p = 32,
    parameter bit saturate_p = 1'b1,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic                 clear_i,
    input  logic [els_p-1:0]     ev_i,
    input  logic                 snapshot_i,
    input  logic [width_p-1:0]   interval_i,
    input  logic                 window_clear_i,
    input  logic                 rd_v_i,
    input  logic [lg_els_lp-1:0] rd_addr_i,
    input  logic                 rd_shadow_i,
    output logic                 rd_ready_o,
    output logic                 rd_v_o,
    output logic [width_p-1:0]   rd_data_o,
    output logic                 rd_ovf_o,
    input  logic                 rd_yumi_i,
    output logic [width_p-1:0]   cycle_o,
    output logic [els_p-1:0]     ovf_o,
    output logic                 window_done_o
);
    typedef logic [width_p-1:0] word_t;

    word_t            cnt_q [els_p];
    word_t            cnt_d [els_p];
    word_t            shadow_q [els_p];
    word_t            shadow_d [els_p];
    logic [els_p-1:0] ovf_q, ovf_d;
    word_t            cycle_q, cycle_d;
    word_t            timer_q, timer_d;
    logic             window_done_q, window_done_d;
    logic             rd_v_q, rd_v_d;
    word_t            rd_data_q, rd_data_d;
    logic             rd_ovf_q, rd_ovf_d;
    logic [els_p-1:0] inc;
    logic             fire, snap, accept, addr_ok;

    function automatic word_t bump(input word_t v);
        return (v == '1) ? (saturate_p ? v : '0) : v + word_t'(1);
    endfunction

    assign inc        = {els_p{en_i}} & ev_i;
    assign fire       = en_i && (interval_i != '0) && (timer_q == interval_i - word_t'(1));
    assign snap       = snapshot_i | fire;
    assign rd_ready_o = ~rd_v_q | rd_yumi_i;
    assign accept     = rd_v_i & rd_ready_o;
    assign addr_ok    = int'(rd_addr_i) < els_p;

    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < els_p; k++) begin
            shadow_d[k] = snap ? cnt_q[k] : shadow_q[k];
            cnt_d[k]    = cnt_q[k];
            if (clear_i) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end else if (fire && window_clear_i) begin
                cnt_d[k] = word_t'(inc[k]);
            end else if (inc[k]) begin
                cnt_d[k] = bump(cnt_q[k]);
                ovf_d[k] = ovf_q[k] | (cnt_q[k] == '1);
            end
        end
        cycle_d       = clear_i ? '0 : (en_i ? bump(cycle_q) : cycle_q);
        timer_d       = (clear_i || interval_i == '0 || fire) ? '0 : (en_i ? timer_q + word_t'(1) : timer_q);
        window_done_d = fire;
        // response register captures pre-edge state so same-cycle counts/snapshots stay invisible
        rd_v_d    = accept | (rd_v_q & ~rd_yumi_i);
        rd_data_d = rd_data_q;
        rd_ovf_d  = rd_ovf_q;
        if (accept) begin
            rd_data_d = addr_ok ? (rd_shadow_i ? shadow_q[rd_addr_i] : cnt_q[rd_addr_i]) : '0;
            rd_ovf_d  = addr_ok ? ovf_q[rd_addr_i] : 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q         <= '{default: '0};
            shadow_q      <= '{default: '0};
            ovf_q         <= '0;
            cycle_q       <= '0;
            timer_q       <= '0;
            window_done_q <= 1'b0;
            rd_v_q        <= 1'b0;
            rd_data_q     <= '0;
            rd_ovf_q      <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            ovf_q         <= ovf_d;
            cycle_q       <= cycle_d;
            timer_q       <= timer_d;
            window_done_q <= window_done_d;
            rd_v_q        <= rd_v_d;
            rd_data_q     <= rd_data_d;
            rd_ovf_q      <= rd_ovf_d;
        end
    end

    assign rd_v_o        = rd_v_q;
    assign rd_data_o     = rd_data_q;
    assign rd_ovf_o      = rd_ovf_q;
    assign cycle_o       = cycle_q;
    assign ovf_o         = ovf_q;
    assign window_done_o = window_done_q;
endmodule
